// File: rtl/mold_req_gen.sv
// mold_req_gen: turns one retransmission request (session, first missing
// sequence number, missing count) into one or more 20-byte MoldUDP64 request
// packets on a 64-bit byte-lane stream, three beats per packet.
module mold_req_gen #(
   parameter int unsigned SEQ_NUM_W   = 18,
   parameter int unsigned SID_W       = 80,
   parameter int unsigned MAX_REQ_CNT = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 req_v_i,
   output logic                 req_rdy_o,
   input  logic [SID_W-1:0]     req_sid_i,
   input  logic [SEQ_NUM_W-1:0] req_seq_start_i,
   input  logic [SEQ_NUM_W-1:0] req_seq_cnt_i,
   output logic                 tx_v_o,
   input  logic                 tx_rdy_i,
   output logic [63:0]          tx_data_o,
   output logic [7:0]           tx_keep_o,
   output logic                 tx_last_o,
   output logic                 busy_o
);

   localparam logic [SEQ_NUM_W-1:0] MAX_CNT = SEQ_NUM_W'(MAX_REQ_CNT);

   typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

   state_t                 state_q, state_d;
   logic [SID_W-1:0]       sid_q;
   logic [SEQ_NUM_W-1:0]   cur_seq_q;
   logic [SEQ_NUM_W-1:0]   remaining_q;
   logic [SEQ_NUM_W-1:0]   pkt_cnt;
   logic [SEQ_NUM_W-1:0]   rem_next;
   logic                   accept;
   logic [159:0]           pkt_be;
   logic [159:0]           pkt_le;
   logic                   tx_v;
   logic [63:0]            tx_data;
   logic [7:0]             tx_keep;
   logic                   tx_last;

   // Messages carried by one packet: the remaining count clipped to the per-packet limit.
   function automatic logic [SEQ_NUM_W-1:0] sat_cnt(input logic [SEQ_NUM_W-1:0] rem);
      return (rem > MAX_CNT) ? MAX_CNT : rem;
   endfunction

   assign req_rdy_o = (state_q == IDLE) & nreset;
   assign accept    = req_v_i & req_rdy_o;
   assign pkt_cnt   = sat_cnt(remaining_q);
   assign rem_next  = remaining_q - pkt_cnt;

   // Assemble the big-endian packet image, then reorder it so byte i sits in lane bits [8i+7:8i].
   always_comb begin
      pkt_be = {80'(sid_q), 64'(cur_seq_q), 16'(pkt_cnt)};
      pkt_le = '0;
      for (int i = 0; i < 20; i++) begin
         pkt_le[8*i +: 8] = pkt_be[159-8*i -: 8];
      end
   end

   // State register; reset drops any packet in flight.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Holding register: latch on accept, advance sequence/remaining after each packet's last beat.
   always_ff @(posedge clk) begin
      if (accept) begin
         sid_q       <= req_sid_i;
         cur_seq_q   <= req_seq_start_i;
         remaining_q <= req_seq_cnt_i;
      end else if (state_q == B2 && tx_rdy_i) begin
         cur_seq_q   <= cur_seq_q + pkt_cnt;
         remaining_q <= rem_next;
      end
   end

   // Next state and beat contents; beats only advance on a downstream handshake.
   always_comb begin
      state_d = state_q;
      tx_v    = 1'b0;
      tx_data = '0;
      tx_keep = '0;
      tx_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && req_seq_cnt_i != '0) state_d = B0;
         end
         B0: begin
            tx_v    = 1'b1;
            tx_data = pkt_le[63:0];
            tx_keep = 8'hFF;
            if (tx_rdy_i) state_d = B1;
         end
         B1: begin
            tx_v    = 1'b1;
            tx_data = pkt_le[127:64];
            tx_keep = 8'hFF;
            if (tx_rdy_i) state_d = B2;
         end
         B2: begin
            tx_v    = 1'b1;
            tx_data = {32'h0, pkt_le[159:128]};
            tx_keep = 8'h0F;
            tx_last = 1'b1;
            if (tx_rdy_i) state_d = (rem_next != '0) ? B0 : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is asserted.
   assign tx_v_o    = tx_v & nreset;
   assign tx_data_o = nreset ? tx_data : 64'h0;
   assign tx_keep_o = nreset ? tx_keep : 8'h0;
   assign tx_last_o = tx_last & nreset;
   assign busy_o    = (state_q != IDLE) & nreset;

endmodule

// File: tb/tb_mold_req_gen.sv
// Bench for mold_req_gen: directed and randomized requests checked beat by beat
// against a packet-level reference model held in queues.
module tb_mold_req_gen;

   localparam int SEQ_NUM_W = 18;
   localparam int MAX_CNT   = 65535;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        req_v_i = 1'b0;
   logic        req_rdy_o;
   logic [79:0] req_sid_i = '0;
   logic [17:0] req_seq_start_i = '0;
   logic [17:0] req_seq_cnt_i = '0;
   logic        tx_v_o;
   logic        tx_rdy_i = 1'b0;
   logic [63:0] tx_data_o;
   logic [7:0]  tx_keep_o;
   logic        tx_last_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_data[$];
   logic [7:0]  exp_keep[$];
   logic        exp_last[$];

   always #5 clk = ~clk;

   mold_req_gen #(.SEQ_NUM_W(18), .SID_W(80), .MAX_REQ_CNT(16'hFFFF)) dut (
      .clk(clk), .nreset(nreset),
      .req_v_i(req_v_i), .req_rdy_o(req_rdy_o),
      .req_sid_i(req_sid_i), .req_seq_start_i(req_seq_start_i), .req_seq_cnt_i(req_seq_cnt_i),
      .tx_v_o(tx_v_o), .tx_rdy_i(tx_rdy_i), .tx_data_o(tx_data_o),
      .tx_keep_o(tx_keep_o), .tx_last_o(tx_last_o), .busy_o(busy_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: expand a request into the expected sequence of wire beats.
   task automatic model(input logic [79:0] sid, input int unsigned start, input int unsigned cnt);
      int unsigned  seq, rem, n;
      byte unsigned b[20];
      logic [63:0]  seq64, d;
      logic [7:0]   k;
      seq = start;
      rem = cnt;
      while (rem > 0) begin
         n = (rem > MAX_CNT) ? MAX_CNT : rem;
         seq64 = 64'(seq);
         for (int i = 0; i < 10; i++) b[i] = sid[79-8*i -: 8];
         for (int i = 0; i < 8; i++) b[10+i] = seq64[63-8*i -: 8];
         b[18] = n[15:8];
         b[19] = n[7:0];
         for (int beat = 0; beat < 3; beat++) begin
            d = '0;
            k = '0;
            for (int l = 0; l < 8; l++) begin
               if (beat*8 + l < 20) begin
                  d[8*l +: 8] = b[beat*8 + l];
                  k[l] = 1'b1;
               end
            end
            exp_data.push_back(d);
            exp_keep.push_back(k);
            exp_last.push_back(beat == 2);
         end
         rem = rem - n;
         seq = (seq + n) % (32'd1 << SEQ_NUM_W);
      end
   endtask

   // Issue one request and follow it to completion; stall_pct randomizes tx_rdy_i,
   // b1_hold holds tx_rdy_i low that many cycles while the first packet sits in B1.
   task automatic do_req(input logic [79:0] sid, input logic [17:0] start, input logic [17:0] cnt,
                         input int stall_pct, input int b1_hold, input string tag);
      int cyc, popped, held, total;
      logic rdy;
      @(negedge clk);
      check({tag, "_rdy_idle"}, 64'(req_rdy_o), 64'd1);
      req_v_i = 1'b1;
      req_sid_i = sid;
      req_seq_start_i = start;
      req_seq_cnt_i = cnt;
      model(sid, 32'(start), 32'(cnt));
      total = exp_data.size();
      @(negedge clk);
      req_v_i = 1'b0;
      cyc = 0;
      popped = 0;
      held = 0;
      while (exp_data.size() > 0 && cyc < 2000) begin
         check({tag, "_valid"}, 64'(tx_v_o), 64'd1);
         check({tag, "_busy"}, 64'(busy_o), 64'd1);
         check({tag, "_rdy_busy"}, 64'(req_rdy_o), 64'd0);
         check({tag, "_data"}, tx_data_o, exp_data[0]);
         check({tag, "_keep"}, 64'(tx_keep_o), 64'(exp_keep[0]));
         check({tag, "_last"}, 64'(tx_last_o), 64'(exp_last[0]));
         rdy = ($urandom_range(99) >= 32'(stall_pct));
         if (popped == 1 && held < b1_hold) begin
            rdy = 1'b0;
            held++;
         end
         tx_rdy_i = rdy;
         if (rdy) begin
            void'(exp_data.pop_front());
            void'(exp_keep.pop_front());
            void'(exp_last.pop_front());
            popped++;
         end
         if (exp_data.size() > 0) begin
            // Garbage request while busy must be ignored.
            req_v_i = 1'b1;
            req_sid_i = 80'({$urandom, $urandom, $urandom});
            req_seq_start_i = 18'($urandom);
            req_seq_cnt_i = 18'($urandom);
         end else begin
            req_v_i = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      if (exp_data.size() > 0) begin
         check({tag, "_timeout"}, 64'(exp_data.size()), 64'd0);
         exp_data.delete();
         exp_keep.delete();
         exp_last.delete();
      end
      req_v_i = 1'b0;
      check({tag, "_transfers"}, 64'(popped), 64'(total));
      check({tag, "_end_valid"}, 64'(tx_v_o), 64'd0);
      check({tag, "_end_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_end_rdy"}, 64'(req_rdy_o), 64'd1);
   endtask

   initial begin
      logic [79:0] rsid;
      logic [17:0] rcnt;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(tx_v_o), 64'd0);
      check("rst_last", 64'(tx_last_o), 64'd0);
      check("rst_keep", 64'(tx_keep_o), 64'd0);
      check("rst_data", tx_data_o, 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_rdy", 64'(req_rdy_o), 64'd0);
      nreset = 1'b1;
      tx_rdy_i = 1'b1;

      do_req(80'h0102030405060708090A, 18'd5, 18'd3, 0, 0, "basic");
      do_req(80'h0102030405060708090A, 18'h10, 18'h20000, 0, 0, "split");
      do_req(80'h0102030405060708090A, 18'd5, 18'd3, 0, 4, "bp_b1");

      // Zero count: consumed, no packet, stays idle
      @(negedge clk);
      req_v_i = 1'b1;
      req_sid_i = 80'hAABB;
      req_seq_start_i = 18'd7;
      req_seq_cnt_i = 18'd0;
      @(negedge clk);
      req_v_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("zero_valid", 64'(tx_v_o), 64'd0);
         check("zero_rdy", 64'(req_rdy_o), 64'd1);
         check("zero_busy", 64'(busy_o), 64'd0);
         @(negedge clk);
      end
      do_req(80'hFEEDFACE, 18'd100, 18'd1, 0, 0, "cnt1");

      // Sequence wrap across split packets and near the top of the range
      do_req(80'h1234, 18'h3FFFF, 18'h10000, 0, 0, "wrap_split");
      do_req(80'h5678, 18'h3FFFE, 18'd6, 20, 0, "wrap");

      // Reset while the first packet's B1 beat is being handed over
      @(negedge clk);
      req_v_i = 1'b1;
      req_sid_i = 80'h0102030405060708090A;
      req_seq_start_i = 18'd5;
      req_seq_cnt_i = 18'd3;
      tx_rdy_i = 1'b1;
      @(negedge clk);
      req_v_i = 1'b0;
      @(negedge clk);
      check("rstmid_in_b1", 64'(tx_keep_o), 64'hFF);
      nreset = 1'b0;
      @(negedge clk);
      check("rstmid_valid", 64'(tx_v_o), 64'd0);
      check("rstmid_busy", 64'(busy_o), 64'd0);
      check("rstmid_rdy", 64'(req_rdy_o), 64'd0);
      nreset = 1'b1;
      @(negedge clk);
      check("rstmid_rdy_after", 64'(req_rdy_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         check("rstmid_no_stale", 64'(tx_v_o), 64'd0);
         @(negedge clk);
      end

      // Randomized requests with random backpressure
      for (int t = 0; t < 25; t++) begin
         rsid = 80'({$urandom, $urandom, $urandom});
         case ($urandom_range(3))
            0: rcnt = 18'($urandom_range(1, 4));
            1: rcnt = 18'($urandom_range(65530, 65540));
            2: rcnt = 18'($urandom_range(1, 18'h3FFFF));
            default: rcnt = 18'd0;
         endcase
         do_req(rsid, 18'($urandom), rcnt, 30, 0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
